// File: rtl/gpu_shader_simd_core_if.sv
// Instruction, retire and host-debug signal bundle for the SIMD shader core.
// master = issuing agent / host, slave = core.
interface gpu_shader_simd_core_if #(
   parameter int LANES  = 4,
   parameter int DATA_W = 32
) ();
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr;
   logic [LANES-1:0]  lane_mask;
   logic              busy;
   logic              retire_valid;
   logic              illegal;
   logic [31:0]       retire_count;
   logic              host_we;
   logic [LW-1:0]     host_lane;
   logic [4:0]        host_reg;
   logic [DATA_W-1:0] host_wdata;
   logic [DATA_W-1:0] dbg_data;

   modport master (
      output instr_valid, instr, lane_mask, host_we, host_lane, host_reg, host_wdata,
      input  instr_ready, busy, retire_valid, illegal, retire_count, dbg_data
   );

   modport slave (
      input  instr_valid, instr, lane_mask, host_we, host_lane, host_reg, host_wdata,
      output instr_ready, busy, retire_valid, illegal, retire_count, dbg_data
   );
endinterface

// File: rtl/gpu_shader_simd_core.sv
// Multicycle SIMD shader core: ALU ops retire 2 cycles after acceptance, LOAD/STORE 3.
// instr_ready is high only in IDLE, so an offered instruction simply waits while busy.
package opcode_pkg;
   localparam logic [5:0] OP_NOP   = 6'h00;
   localparam logic [5:0] OP_ADD   = 6'h01;
   localparam logic [5:0] OP_SUB   = 6'h02;
   localparam logic [5:0] OP_MUL   = 6'h03;
   localparam logic [5:0] OP_AND   = 6'h04;
   localparam logic [5:0] OP_OR    = 6'h05;
   localparam logic [5:0] OP_XOR   = 6'h06;
   localparam logic [5:0] OP_ADDI  = 6'h07;
   localparam logic [5:0] OP_LOAD  = 6'h10;
   localparam logic [5:0] OP_STORE = 6'h11;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  dst;
      logic [4:0]  src0;
      logic [4:0]  src1;
      logic [10:0] immd;
   } instr_t;
endpackage

module gpu_shader_simd_core
   import opcode_pkg::*;
#(
   parameter int LANES     = 4,
   parameter int DATA_W    = 32,
   parameter int REGS      = 32,
   parameter int MEM_DEPTH = 256
) (
   input  logic clk,
   input  logic rst_n,
   gpu_shader_simd_core_if.slave bus
);
   localparam int AW = $clog2(MEM_DEPTH);
   localparam int RW = (REGS > 1) ? $clog2(REGS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;

   state_t            state, state_nx;
   instr_t            ir;
   logic [LANES-1:0]  mask_q;
   logic [DATA_W-1:0] rf     [LANES][REGS];
   logic [DATA_W-1:0] bank   [LANES][MEM_DEPTH];
   logic [DATA_W-1:0] res_q  [LANES];
   logic [DATA_W-1:0] sdat_q [LANES];
   logic [AW-1:0]     addr_q [LANES];
   logic [DATA_W-1:0] res_c  [LANES];
   logic [DATA_W-1:0] sdat_c [LANES];
   logic [AW-1:0]     addr_c [LANES];
   logic [DATA_W-1:0] imm_ext;
   logic [31:0]       retire_cnt;
   logic              is_legal, is_mem, wb_en;

   // r0 and indices beyond the register file read as zero.
   function automatic logic [DATA_W-1:0] reg_rd(input int l, input logic [4:0] idx);
      if (idx == 5'd0 || int'(idx) >= REGS || l >= LANES)
         return '0;
      return rf[l][idx[RW-1:0]];
   endfunction

   assign imm_ext = {{(DATA_W-11){ir.immd[10]}}, ir.immd};

   always_comb begin
      is_legal = 1'b0;
      case (ir.opcode)
         OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR,
         OP_ADDI, OP_LOAD, OP_STORE: is_legal = 1'b1;
         default: is_legal = 1'b0;
      endcase
      is_mem = (ir.opcode == OP_LOAD) || (ir.opcode == OP_STORE);
      wb_en  = is_legal && (ir.opcode != OP_NOP) && (ir.opcode != OP_STORE);
   end

   always_comb begin : exec_lanes
      logic [DATA_W-1:0] a, b, sum;
      a = '0;
      b = '0;
      sum = '0;
      for (int l = 0; l < LANES; l++) begin
         a         = reg_rd(l, ir.src0);
         b         = reg_rd(l, ir.src1);
         sum       = a + imm_ext;
         addr_c[l] = sum[AW-1:0];
         sdat_c[l] = b;
         case (ir.opcode)
            OP_ADD:  res_c[l] = a + b;
            OP_SUB:  res_c[l] = a - b;
            OP_MUL:  res_c[l] = a * b;
            OP_AND:  res_c[l] = a & b;
            OP_OR:   res_c[l] = a | b;
            OP_XOR:  res_c[l] = a ^ b;
            OP_ADDI: res_c[l] = sum;
            default: res_c[l] = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.instr_valid) state_nx = S_EXEC;
         S_EXEC:  state_nx = is_mem ? S_MEM : S_WB;
         S_MEM:   state_nx = S_WB;
         S_WB:    state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir         <= '0;
         mask_q     <= '0;
         retire_cnt <= '0;
         for (int l = 0; l < LANES; l++) begin
            res_q[l]  <= '0;
            sdat_q[l] <= '0;
            addr_q[l] <= '0;
            for (int r = 0; r < REGS; r++)
               rf[l][r] <= '0;
         end
      end else begin
         // Host write lands at the same edge as acceptance, so EXEC sees it.
         if (state == S_IDLE && bus.host_we && int'(bus.host_lane) < LANES &&
             bus.host_reg != 5'd0 && int'(bus.host_reg) < REGS)
            rf[bus.host_lane][bus.host_reg[RW-1:0]] <= bus.host_wdata;
         if (state == S_IDLE && bus.instr_valid) begin
            ir     <= instr_t'(bus.instr);
            mask_q <= bus.lane_mask;
         end
         for (int l = 0; l < LANES; l++) begin
            if (state == S_EXEC) begin
               res_q[l]  <= res_c[l];
               sdat_q[l] <= sdat_c[l];
               addr_q[l] <= addr_c[l];
            end
            if (state == S_MEM && ir.opcode == OP_LOAD)
               res_q[l] <= bank[l][addr_q[l]];
            if (state == S_WB && wb_en && mask_q[l] && ir.dst != 5'd0 && int'(ir.dst) < REGS)
               rf[l][ir.dst[RW-1:0]] <= res_q[l];
         end
         if (state == S_WB)
            retire_cnt <= retire_cnt + 32'd1;
      end
   end

   // Scratchpad holds no reset; an aborted STORE never reaches this edge in MEM.
   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES; l++)
         if (state == S_MEM && ir.opcode == OP_STORE && mask_q[l])
            bank[l][addr_q[l]] <= sdat_q[l];
   end

   assign bus.instr_ready  = (state == S_IDLE);
   assign bus.busy         = (state != S_IDLE);
   assign bus.retire_valid = (state == S_WB);
   assign bus.illegal      = (state == S_WB) && !is_legal;
   assign bus.retire_count = retire_cnt;
   assign bus.dbg_data     = reg_rd(int'(bus.host_lane), bus.host_reg);
endmodule

// File: tb/tb_gpu_shader_simd_core.sv
// Directed-vector bench for gpu_shader_simd_core: table of instructions with expected
// per-lane results, plus hand sequences for back-to-back issue and reset during MEM.
module tb_gpu_shader_simd_core;
   localparam int LANES = 4;
   localparam int DW    = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   gpu_shader_simd_core_if #(.LANES(LANES), .DATA_W(DW)) bus ();

   gpu_shader_simd_core #(.LANES(LANES), .DATA_W(DW), .REGS(32), .MEM_DEPTH(256)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0]          ins;
      logic [3:0]           mask;
      logic [3:0]           lat;
      logic                 ill;
      logic [4:0]           creg;
      logic [3:0][DW-1:0]   exp;
   } vec_t;

   function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] d,
                                       input logic [4:0] s0, input logic [4:0] s1,
                                       input logic [10:0] imm);
      return {op, d, s0, s1, imm};
   endfunction

   function automatic vec_t mk(input logic [31:0] ins, input logic [3:0] mask,
                               input logic [3:0] lat, input logic ill, input logic [4:0] creg,
                               input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                               input logic [DW-1:0] e2, input logic [DW-1:0] e3);
      vec_t v;
      v.ins = ins; v.mask = mask; v.lat = lat; v.ill = ill; v.creg = creg;
      v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
      return v;
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic read_dbg(input int lane, input int r, output logic [DW-1:0] d);
      bus.host_lane = lane[1:0];
      bus.host_reg  = r[4:0];
      #1;
      d = bus.dbg_data;
   endtask

   task automatic host_write(input int lane, input int r, input logic [DW-1:0] d);
      @(negedge clk);
      bus.host_we    = 1'b1;
      bus.host_lane  = lane[1:0];
      bus.host_reg   = r[4:0];
      bus.host_wdata = d;
      @(posedge clk);
      #1 bus.host_we = 1'b0;
   endtask

   // Offers one instruction in IDLE; returns cycles from acceptance to retire_valid.
   task automatic issue(input logic [31:0] ins, input logic [3:0] mask,
                        output int lat, output logic ill);
      lat = 0;
      ill = 1'b0;
      @(negedge clk);
      bus.instr       = ins;
      bus.lane_mask   = mask;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (bus.retire_valid) begin
            lat = k;
            ill = bus.illegal;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t        vecs [17];
   int          lat;
   logic        ill;
   logic [DW-1:0] d;
   logic [31:0] c0;
   int          acc, rets, errs;

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      bus.lane_mask   = '0;
      bus.host_we     = 1'b0;
      bus.host_lane   = '0;
      bus.host_reg    = '0;
      bus.host_wdata  = '0;

      vecs[0]  = mk(enc(6'h01, 5'd3, 5'd1, 5'd2, 11'd0),     4'hF, 4'd2, 1'b0, 5'd3, 11, 12, 13, 14);
      vecs[1]  = mk(enc(6'h11, 5'd0, 5'd0, 5'd3, 11'd5),     4'hF, 4'd3, 1'b0, 5'd3, 11, 12, 13, 14);
      vecs[2]  = mk(enc(6'h10, 5'd4, 5'd0, 5'd0, 11'd5),     4'h5, 4'd3, 1'b0, 5'd4, 11, 0, 13, 0);
      vecs[3]  = mk(enc(6'h07, 5'd5, 5'd0, 5'd0, 11'h7FF),   4'hF, 4'd2, 1'b0, 5'd5,
                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      vecs[4]  = mk(enc(6'h01, 5'd6, 5'd5, 5'd1, 11'd0),     4'hF, 4'd2, 1'b0, 5'd6, 0, 1, 2, 3);
      vecs[5]  = mk(enc(6'h11, 5'd0, 5'd0, 5'd2, 11'h0FF),   4'hF, 4'd3, 1'b0, 5'd2, 10, 10, 10, 10);
      vecs[6]  = mk(enc(6'h10, 5'd7, 5'd0, 5'd0, 11'h3FF),   4'hF, 4'd3, 1'b0, 5'd7, 10, 10, 10, 10);
      vecs[7]  = mk(enc(6'h02, 5'd8, 5'd1, 5'd2, 11'd0),     4'hF, 4'd2, 1'b0, 5'd8,
                    32'hFFFF_FFF7, 32'hFFFF_FFF8, 32'hFFFF_FFF9, 32'hFFFF_FFFA);
      vecs[8]  = mk(enc(6'h03, 5'd9, 5'd1, 5'd2, 11'd0),     4'hA, 4'd2, 1'b0, 5'd9, 0, 20, 0, 40);
      vecs[9]  = mk(enc(6'h04, 5'd10, 5'd3, 5'd1, 11'd0),    4'hF, 4'd2, 1'b0, 5'd10, 1, 0, 1, 4);
      vecs[10] = mk(enc(6'h05, 5'd11, 5'd3, 5'd1, 11'd0),    4'hF, 4'd2, 1'b0, 5'd11, 11, 14, 15, 14);
      vecs[11] = mk(enc(6'h06, 5'd12, 5'd3, 5'd1, 11'd0),    4'hF, 4'd2, 1'b0, 5'd12, 10, 14, 14, 10);
      vecs[12] = mk(enc(6'h01, 5'd0, 5'd1, 5'd2, 11'd0),     4'hF, 4'd2, 1'b0, 5'd0, 0, 0, 0, 0);
      vecs[13] = mk(enc(6'h3F, 5'd13, 5'd1, 5'd2, 11'd0),    4'hF, 4'd2, 1'b1, 5'd13, 0, 0, 0, 0);
      vecs[14] = mk(enc(6'h00, 5'd14, 5'd1, 5'd2, 11'd0),    4'hF, 4'd2, 1'b0, 5'd14, 0, 0, 0, 0);
      vecs[15] = mk(enc(6'h01, 5'd15, 5'd1, 5'd2, 11'd0),    4'h0, 4'd2, 1'b0, 5'd15, 0, 0, 0, 0);
      vecs[16] = mk(enc(6'h07, 5'd16, 5'd1, 5'd0, 11'h7FE),  4'hF, 4'd2, 1'b0, 5'd16,
                    32'hFFFF_FFFF, 0, 1, 2);

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, bus.busy}, 0);
      check("rst_ready", {31'd0, bus.instr_ready}, 1);
      check("rst_retire_valid", {31'd0, bus.retire_valid}, 0);
      check("rst_illegal", {31'd0, bus.illegal}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_retire_count", bus.retire_count, 0);
      read_dbg(2, 1, d);
      check("rst_reg", d, 0);

      for (int l = 0; l < LANES; l++) begin
         host_write(l, 1, DW'(l + 1));
         host_write(l, 2, 32'd10);
      end

      for (int i = 0; i < 17; i++) begin
         issue(vecs[i].ins, vecs[i].mask, lat, ill);
         check($sformatf("v%0d_latency", i), DW'(lat), DW'(vecs[i].lat));
         check($sformatf("v%0d_illegal", i), {31'd0, ill}, {31'd0, vecs[i].ill});
         @(negedge clk);
         check($sformatf("v%0d_ready", i), {31'd0, bus.instr_ready}, 1);
         check($sformatf("v%0d_count", i), bus.retire_count, DW'(i + 1));
         for (int l = 0; l < LANES; l++) begin
            read_dbg(l, int'(vecs[i].creg), d);
            check($sformatf("v%0d_lane%0d_r%0d", i, l, vecs[i].creg), d, vecs[i].exp[l]);
         end
      end

      // Back-to-back issue with instr_valid held; host write during EXEC is dropped.
      c0 = bus.retire_count;
      acc = 0;
      rets = 0;
      for (int cyc = 0; cyc < 9; cyc++) begin
         @(negedge clk);
         if (cyc == 0) begin
            bus.instr       = enc(6'h01, 5'd20, 5'd1, 5'd2, 11'd0);
            bus.lane_mask   = 4'hF;
            bus.instr_valid = 1'b1;
         end
         bus.host_we    = (cyc == 1);
         bus.host_lane  = 2'd0;
         bus.host_reg   = 5'd21;
         bus.host_wdata = 32'hDEAD;
         #1;
         if (bus.instr_ready) acc++;
         if (bus.retire_valid) rets++;
         check($sformatf("b2b_ready_vs_busy_%0d", cyc), {31'd0, bus.instr_ready}, {31'd0, ~bus.busy});
      end
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.host_we     = 1'b0;
      check("b2b_acceptances", DW'(acc), 3);
      check("b2b_retires", DW'(rets), 3);
      check("b2b_count", bus.retire_count, c0 + 32'd3);
      read_dbg(0, 21, d);
      check("b2b_host_we_ignored", d, 0);
      for (int l = 0; l < LANES; l++) begin
         read_dbg(l, 20, d);
         check($sformatf("b2b_lane%0d_r20", l), d, DW'(11 + l));
      end

      // Reset asserted while a STORE sits in MEM.
      @(negedge clk);
      bus.instr       = enc(6'h11, 5'd0, 5'd0, 5'd1, 11'd7);
      bus.lane_mask   = 4'hF;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mem_busy_before_reset", {31'd0, bus.busy}, 1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, bus.busy}, 0);
      check("arst_ready", {31'd0, bus.instr_ready}, 1);
      check("arst_retire_valid", {31'd0, bus.retire_valid}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      check("arst_count", bus.retire_count, 0);
      errs = 0;
      for (int l = 0; l < LANES; l++)
         for (int r = 0; r < 32; r++) begin
            read_dbg(l, r, d);
            if (d !== '0) errs++;
         end
      check("arst_regs_nonzero", DW'(errs), 0);
      rets = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.retire_valid) rets++;
      end
      check("arst_no_retire", DW'(rets), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
